// File: rtl/sb_tx_serializer.sv
// Sideband transmitter: buffers 64-bit messages in a FIFO and serializes each MSB-first
// on a forwarded clock, followed by a 32-UI gap. Define SB_TX_OVF_EN to build the sticky overflow flag.
module sb_tx_serializer #(
    parameter int buffer_size = 4
) (
    input  logic        clk_800MHz,
    input  logic        reset,
    input  logic        enable_i,
    input  logic [63:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        dataPin_o,
    output logic        clkPin_o,
    output logic        busy_o,
    output logic        overflow_o
);

    localparam int AW = $clog2(buffer_size);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [5:0]  ui_q, ui_d;
    logic [63:0] shift_q, shift_d;
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        data_pin_q, data_pin_d;
    logic        clk_pin_q, clk_pin_d;
    logic        busy_q, busy_d;
    logic [63:0] mem_q [buffer_size];

    logic        empty_s;
    logic        full_s;
    logic        wr_s;
    logic        ui_end_s;
    logic        start_s;

    // Pointer MSB differs only when the write side has lapped the read side.
    always_comb begin
        empty_s  = (wptr_q == rptr_q);
        full_s   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        wr_s     = valid_i && !full_s;
        ui_end_s = phase_q &&
                   (((state_q == ST_DATA) && (ui_q == 6'd63)) ||
                    ((state_q == ST_GAP)  && (ui_q == 6'd31)));
        start_s  = enable_i && !empty_s &&
                   ((state_q == ST_IDLE) || ((state_q == ST_GAP) && ui_end_s));
    end

    assign ready_o = !full_s;

    // FIFO pointer update; full is judged before any same-cycle pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_s) begin
            wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wptr_d = wptr_q;
        end
        if (start_s) begin
            rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rptr_d = rptr_q;
        end
    end

    // Message sequencer: each UI is a high phase then a low phase of the forwarded clock.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        ui_d    = ui_q;
        shift_d = shift_q;
        case (state_q)
            ST_IDLE: begin
                phase_d = 1'b0;
                ui_d    = 6'd0;
                if (start_s) begin
                    state_d = ST_DATA;
                    shift_d = mem_q[rptr_q[AW-1:0]];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                phase_d = !phase_q;
                if (phase_q) begin
                    shift_d = {shift_q[62:0], 1'b0};
                    if (ui_q == 6'd63) begin
                        state_d = ST_GAP;
                        ui_d    = 6'd0;
                    end else begin
                        ui_d    = ui_q + 6'd1;
                    end
                end else begin
                    shift_d = shift_q;
                end
            end
            ST_GAP: begin
                phase_d = !phase_q;
                if (phase_q) begin
                    if (ui_q == 6'd31) begin
                        ui_d = 6'd0;
                        if (start_s) begin
                            state_d = ST_DATA;
                            shift_d = mem_q[rptr_q[AW-1:0]];
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        ui_d = ui_q + 6'd1;
                    end
                end else begin
                    ui_d = ui_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = 1'b0;
                ui_d    = 6'd0;
            end
        endcase
    end

    // Pin values reflect the sequencer state of the previous cycle.
    always_comb begin
        clk_pin_d  = (state_q != ST_IDLE) && !phase_q;
        data_pin_d = (state_q == ST_DATA) && shift_q[63];
        busy_d     = (state_d != ST_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk_800MHz or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= 1'b0;
            ui_q       <= 6'd0;
            shift_q    <= 64'd0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            data_pin_q <= 1'b0;
            clk_pin_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            ui_q       <= ui_d;
            shift_q    <= shift_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            data_pin_q <= data_pin_d;
            clk_pin_q  <= clk_pin_d;
            busy_q     <= busy_d;
        end
    end

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk_800MHz) begin
        if (wr_s) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

    assign dataPin_o = data_pin_q;
    assign clkPin_o  = clk_pin_q;
    assign busy_o    = busy_q;

`ifdef SB_TX_OVF_EN
    logic overflow_q, overflow_d;

    // Sticky record of any refused write.
    always_comb begin
        overflow_d = overflow_q | (valid_i & full_s);
    end

    // Overflow flag register.
    always_ff @(posedge clk_800MHz or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Directed self-checking bench for sb_tx_serializer: decodes the serial pins at each
// falling edge of clkPin_o and compares against hand-chosen message words.
module tb_sb_tx_serializer;

    logic        clk_800MHz = 1'b0;
    logic        reset;
    logic        enable_i;
    logic [63:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic        dataPin_o;
    logic        clkPin_o;
    logic        busy_o;
    logic        overflow_o;

    int checks   = 0;
    int failures = 0;

    logic bits[$];
    int   busy_total = 0;
    int   busy_falls = 0;
    int   rise_total = 0;
    int   hold_err   = 0;
    logic prev_clk   = 1'b0;
    logic prev_data  = 1'b0;
    logic prev_busy  = 1'b0;

    sb_tx_serializer #(.buffer_size(4)) dut (
        .clk_800MHz (clk_800MHz),
        .reset      (reset),
        .enable_i   (enable_i),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .dataPin_o  (dataPin_o),
        .clkPin_o   (clkPin_o),
        .busy_o     (busy_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_800MHz = ~clk_800MHz;

    // Serial receiver model: samples the pins shortly after each rising system clock edge.
    always @(posedge clk_800MHz) begin
        #2;
        if (busy_o) busy_total++;
        if (prev_busy && !busy_o) busy_falls++;
        if (prev_clk && !clkPin_o) begin
            bits.push_back(dataPin_o);
            if (dataPin_o !== prev_data) hold_err++;
        end
        if (!prev_clk && clkPin_o) rise_total++;
        prev_clk  = clkPin_o;
        prev_data = dataPin_o;
        prev_busy = busy_o;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Checks message number idx (96 received bits each) counted from bit index base.
    task automatic check_msg(input string tag, input int base, input int idx, input logic [63:0] exp);
        logic [63:0] w;
        logic [31:0] g;
        int p;
        w = 64'd0;
        g = 32'd0;
        p = base + idx * 96;
        if (bits.size() >= p + 96) begin
            for (int k = 0; k < 64; k++) w = {w[62:0], bits[p + k]};
            for (int k = 0; k < 32; k++) g = {g[30:0], bits[p + 64 + k]};
        end else begin
            w = ~exp;
        end
        check_val({tag, "_data"}, w, exp);
        check_val({tag, "_gap"}, {32'd0, g}, 64'd0);
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n;
        n = 0;
        repeat (3) @(negedge clk_800MHz);
        while (busy_o && n < limit) begin
            @(negedge clk_800MHz);
            n++;
        end
        check_val({tag, "_idle"}, 64'(busy_o), 64'd0);
        repeat (2) @(negedge clk_800MHz);
    endtask

    logic [63:0] wv [10];
    int bb, bu, bf, rb, acc, i, guard;

    initial begin
        reset    = 1'b1;
        enable_i = 1'b0;
        valid_i  = 1'b0;
        data_i   = 64'd0;
        repeat (3) @(negedge clk_800MHz);
        check_val("rst_data",  64'(dataPin_o),  64'd0);
        check_val("rst_clk",   64'(clkPin_o),   64'd0);
        check_val("rst_busy",  64'(busy_o),     64'd0);
        check_val("rst_ovf",   64'(overflow_o), 64'd0);
        check_val("rst_ready", 64'(ready_o),    64'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk_800MHz);

        // Single message and its exact latency.
        bb = bits.size(); bu = busy_total;
        enable_i = 1'b1;
        valid_i  = 1'b1;
        data_i   = 64'hA5A5_0000_FFFF_1234;
        @(negedge clk_800MHz);
        valid_i = 1'b0;
        check_val("lat_n0_busy", 64'(busy_o),   64'd0);
        check_val("lat_n0_clk",  64'(clkPin_o), 64'd0);
        @(negedge clk_800MHz);
        check_val("lat_n1_busy", 64'(busy_o),   64'd1);
        check_val("lat_n1_clk",  64'(clkPin_o), 64'd0);
        @(negedge clk_800MHz);
        check_val("lat_n2_clk",  64'(clkPin_o),  64'd1);
        check_val("lat_n2_data", 64'(dataPin_o), 64'd1);
        @(negedge clk_800MHz);
        check_val("lat_n3_clk",  64'(clkPin_o),  64'd0);
        check_val("lat_n3_data", 64'(dataPin_o), 64'd1);
        wait_idle("single", 400);
        check_val("single_bits", 64'(bits.size() - bb), 64'd96);
        check_val("single_busy", 64'(busy_total - bu), 64'd192);
        check_msg("single", bb, 0, 64'hA5A5_0000_FFFF_1234);

        // Fill: six consecutive writes, the sixth meets a full FIFO.
        for (int k = 0; k < 6; k++) wv[k] = {8'(k + 1), 56'h3C_9600_F00F_C3A5};
        bb = bits.size(); bu = busy_total; bf = busy_falls;
        for (int k = 0; k < 6; k++) begin
            valid_i = 1'b1;
            data_i  = wv[k];
            check_val($sformatf("fill_rdy%0d", k), 64'(ready_o), (k < 5) ? 64'd1 : 64'd0);
            @(negedge clk_800MHz);
        end
        valid_i = 1'b0;
`ifdef SB_TX_OVF_EN
        check_val("fill_ovf", 64'(overflow_o), 64'd1);
`else
        check_val("fill_ovf", 64'(overflow_o), 64'd0);
`endif
        wait_idle("fill", 1200);
        check_val("fill_bits",  64'(bits.size() - bb), 64'd480);
        check_val("fill_busy",  64'(busy_total - bu), 64'd960);
        check_val("fill_b2b",   64'(busy_falls - bf), 64'd1);
        for (int k = 0; k < 5; k++) check_msg($sformatf("fill%0d", k), bb, k, wv[k]);

        // Pointer wrap: ten words pushed whenever there is room.
        for (int k = 0; k < 10; k++) wv[k] = {4'(k), 60'hF0E_D1C2_B3A4_9586} ^ {32'd0, 32'(k * 7919)};
        bb = bits.size();
        i = 0; guard = 0;
        while (i < 10 && guard < 3000) begin
            valid_i = 1'b1;
            data_i  = wv[i];
            acc     = int'(ready_o);
            @(negedge clk_800MHz);
            if (acc != 0) i++;
            guard++;
        end
        valid_i = 1'b0;
        check_val("wrap_accepted", 64'(i), 64'd10);
        wait_idle("wrap", 2500);
        check_val("wrap_bits", 64'(bits.size() - bb), 64'd960);
        for (int k = 0; k < 10; k++) check_msg($sformatf("wrap%0d", k), bb, k, wv[k]);

        // Enable gating.
        enable_i = 1'b0;
        bb = bits.size(); rb = rise_total;
        valid_i = 1'b1; data_i = 64'h8001_2345_6789_ABCD;
        @(negedge clk_800MHz);
        data_i = 64'h7FFE_DCBA_9876_5432;
        @(negedge clk_800MHz);
        valid_i = 1'b0;
        repeat (20) @(negedge clk_800MHz);
        check_val("gate_norise", 64'(rise_total - rb), 64'd0);
        check_val("gate_nobusy", 64'(busy_o), 64'd0);
        enable_i = 1'b1;
        repeat (12) @(negedge clk_800MHz);
        enable_i = 1'b0;
        wait_idle("gate1", 400);
        repeat (30) @(negedge clk_800MHz);
        check_val("gate1_bits",  64'(bits.size() - bb), 64'd96);
        check_val("gate1_rises", 64'(rise_total - rb), 64'd96);
        check_val("gate_parked", 64'(busy_o), 64'd0);
        check_msg("gate1", bb, 0, 64'h8001_2345_6789_ABCD);
        enable_i = 1'b1;
        wait_idle("gate2", 400);
        check_val("gate2_bits", 64'(bits.size() - bb), 64'd192);
        check_msg("gate2", bb, 1, 64'h7FFE_DCBA_9876_5432);
        check_val("hold", 64'(hold_err), 64'd0);

        // Reset during DATA UI 20 with a second word still queued.
        valid_i = 1'b1; data_i = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk_800MHz);
        data_i = 64'h1357_9BDF_2468_ACE0;
        @(negedge clk_800MHz);
        valid_i = 1'b0;
        repeat (41) @(negedge clk_800MHz);
        check_val("pre_rst_busy", 64'(busy_o), 64'd1);
        reset = 1'b1;
        #1;
        check_val("mid_rst_data",  64'(dataPin_o), 64'd0);
        check_val("mid_rst_clk",   64'(clkPin_o),  64'd0);
        check_val("mid_rst_busy",  64'(busy_o),    64'd0);
        check_val("mid_rst_ready", 64'(ready_o),   64'd1);
        @(negedge clk_800MHz);
        reset = 1'b0;
        @(negedge clk_800MHz);
        bb = bits.size(); rb = rise_total;
        repeat (40) @(negedge clk_800MHz);
        check_val("post_rst_norise", 64'(rise_total - rb), 64'd0);
        check_val("post_rst_nobusy", 64'(busy_o), 64'd0);
        valid_i = 1'b1; data_i = 64'h0F1E_2D3C_4B5A_6978;
        @(negedge clk_800MHz);
        valid_i = 1'b0;
        wait_idle("post_rst", 400);
        check_val("post_rst_bits", 64'(bits.size() - bb), 64'd96);
        check_msg("post_rst", bb, 0, 64'h0F1E_2D3C_4B5A_6978);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
